// File: rtl/acionador_estufa.sv
// acionador_estufa: greenhouse actuator back-end, round-robin hysteresis control.
// Optional macro CONTAGEM_ACIONAMENTOS_EN enables the actuator turn-on counter.
module acionador_estufa #(
  parameter int HISTERESE  = 1,
  parameter int MIN_RONDAS = 2,
  parameter int PAUSA      = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] temperatura,
  input  logic [3:0] umidade,
  input  logic [3:0] luminosidade,
  input  logic [3:0] pH,
  input  logic [3:0] ideal_temperatura,
  input  logic [3:0] ideal_umidade,
  input  logic [3:0] ideal_luminosidade,
  input  logic [3:0] ideal_pH,
  output logic       aquecedor,
  output logic       resfriador,
  output logic       irrigador,
  output logic       lampada,
  output logic       dosador_base,
  output logic       dosador_acido,
  output logic [1:0] canal,
  output logic       ocupado,
  output logic [7:0] acionamentos
);

  localparam logic [4:0] LP_H   = 5'(HISTERESE);
  localparam logic [3:0] LP_MIN = 4'(MIN_RONDAS);
  localparam logic [7:0] LP_ULT = 8'(PAUSA - 1);

  typedef enum logic [2:0] {
    OCIOSO, AMOSTRA, AVALIA, ATUA, ESPERA
  } estado_t;

  estado_t         r_estado;
  estado_t         w_prox;
  logic [1:0]      r_canal;
  logic [7:0]      r_pausa;
  logic [3:0]      r_sens;
  logic [3:0]      r_ideal;
  logic [3:0]      r_up;
  logic [3:0]      r_dn;
  logic [3:0][3:0] r_hold;
  logic            r_dec_up;
  logic            r_dec_dn;
  logic [3:0]      r_dec_hold;
  logic [3:0]      w_sens;
  logic [3:0]      w_ideal;
  logic [4:0]      w_lo;
  logic [4:0]      w_hi_raw;
  logic [4:0]      w_hi;
  logic            w_duplo;
  logic            w_sobe;
  logic            w_desce;
  logic            w_up;
  logic            w_dn;
  logic [3:0]      w_hold;
  logic            w_exp;

  assign w_exp = (r_pausa == LP_ULT);

  // state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_estado <= OCIOSO;
    else        r_estado <= w_prox;
  end

  // next-state logic
  always_comb begin
    w_prox = r_estado;
    unique case (r_estado)
      OCIOSO:  if (enable) w_prox = AMOSTRA;
      AMOSTRA: w_prox = AVALIA;
      AVALIA:  w_prox = ATUA;
      ATUA:    w_prox = ESPERA;
      ESPERA:  if (w_exp) w_prox = enable ? AMOSTRA : OCIOSO;
      default: w_prox = OCIOSO;
    endcase
  end

  // state-derived outputs
  always_comb begin
    ocupado = (r_estado != OCIOSO);
  end

  // select sensor/ideal pair of the serviced channel
  always_comb begin
    w_sens  = temperatura;
    w_ideal = ideal_temperatura;
    case (r_canal)
      2'd1: begin w_sens = umidade;      w_ideal = ideal_umidade;      end
      2'd2: begin w_sens = luminosidade; w_ideal = ideal_luminosidade; end
      2'd3: begin w_sens = pH;           w_ideal = ideal_pH;           end
      default: ;
    endcase
  end

  assign w_lo     = ({1'b0, r_ideal} >= LP_H) ? {1'b0, r_ideal} - LP_H : 5'd0;
  assign w_hi_raw = {1'b0, r_ideal} + LP_H;
  assign w_hi     = (w_hi_raw > 5'd15) ? 5'd15 : w_hi_raw;
  assign w_duplo  = (r_canal == 2'd0) || (r_canal == 2'd3);
  assign w_sobe   = ({1'b0, r_sens} < w_lo);
  assign w_desce  = ({1'b0, r_sens} > w_hi) && w_duplo;

  // decision: hold, reversal, or follow the request
  always_comb begin
    w_up   = r_up[r_canal];
    w_dn   = r_dn[r_canal];
    w_hold = r_hold[r_canal];
    if (r_hold[r_canal] != 4'd0) begin
      w_hold = r_hold[r_canal] - 4'd1;
    end else begin
      w_up = 1'b0;
      w_dn = 1'b0;
      unique case (1'b1)
        w_sobe:  w_up = ~r_dn[r_canal];
        w_desce: w_dn = ~r_up[r_canal];
        default: ;
      endcase
      if ((w_up & ~r_up[r_canal]) | (w_dn & ~r_dn[r_canal]))
        w_hold = LP_MIN;
    end
  end

  // sample inputs, register decision, apply it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sens     <= 4'd0;
      r_ideal    <= 4'd0;
      r_dec_up   <= 1'b0;
      r_dec_dn   <= 1'b0;
      r_dec_hold <= 4'd0;
      r_up       <= 4'd0;
      r_dn       <= 4'd0;
      r_hold     <= '0;
    end else begin
      if (r_estado == AMOSTRA) begin
        r_sens  <= w_sens;
        r_ideal <= w_ideal;
      end
      if (r_estado == AVALIA) begin
        r_dec_up   <= w_up;
        r_dec_dn   <= w_dn;
        r_dec_hold <= w_hold;
      end
      if (r_estado == ATUA) begin
        r_up[r_canal]   <= r_dec_up;
        r_dn[r_canal]   <= r_dec_dn;
        r_hold[r_canal] <= r_dec_hold;
      end
    end
  end

  // pause counter and channel rotation
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pausa <= 8'd0;
      r_canal <= 2'd0;
    end else if (r_estado == ATUA) begin
      r_pausa <= 8'd0;
    end else if (r_estado == ESPERA) begin
      if (w_exp) r_canal <= r_canal + 2'd1;
      else       r_pausa <= r_pausa + 8'd1;
    end
  end

`ifdef CONTAGEM_ACIONAMENTOS_EN
  logic [7:0] r_acion;
  logic [1:0] w_sub;
  logic [8:0] w_soma;

  assign w_sub  = {1'b0, r_dec_up & ~r_up[r_canal]}
                + {1'b0, r_dec_dn & ~r_dn[r_canal]};
  assign w_soma = {1'b0, r_acion} + {7'd0, w_sub};

  // saturating count of turn-ons applied on ATUA edges
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                r_acion <= 8'd0;
    else if (r_estado == ATUA) r_acion <= w_soma[8] ? 8'hFF : w_soma[7:0];
  end

  assign acionamentos = r_acion;
`else
  assign acionamentos = 8'd0;
`endif

  assign aquecedor     = r_up[0];
  assign resfriador    = r_dn[0];
  assign irrigador     = r_up[1];
  assign lampada       = r_up[2];
  assign dosador_base  = r_up[3];
  assign dosador_acido = r_dn[3];
  assign canal         = r_canal;

endmodule

// File: tb/tb_acionador_estufa.sv
// tb_acionador_estufa: directed tables, corner sequences and random visits
// against a per-visit direction model of the greenhouse actuators.
module tb_acionador_estufa;

  localparam int H   = 1;
  localparam int MIN = 2;
  localparam int PA  = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] temperatura, umidade, luminosidade, pH;
  logic [3:0] ideal_temperatura, ideal_umidade;
  logic [3:0] ideal_luminosidade, ideal_pH;
  logic       aquecedor, resfriador, irrigador, lampada;
  logic       dosador_base, dosador_acido;
  logic [1:0] canal;
  logic       ocupado;
  logic [7:0] acionamentos;
  logic [5:0] w_out;

  int total = 0;
  int bad   = 0;

  acionador_estufa #(
    .HISTERESE(H), .MIN_RONDAS(MIN), .PAUSA(PA)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .temperatura(temperatura), .umidade(umidade),
    .luminosidade(luminosidade), .pH(pH),
    .ideal_temperatura(ideal_temperatura),
    .ideal_umidade(ideal_umidade),
    .ideal_luminosidade(ideal_luminosidade),
    .ideal_pH(ideal_pH),
    .aquecedor(aquecedor), .resfriador(resfriador),
    .irrigador(irrigador), .lampada(lampada),
    .dosador_base(dosador_base), .dosador_acido(dosador_acido),
    .canal(canal), .ocupado(ocupado),
    .acionamentos(acionamentos)
  );

  always #5 clock = ~clock;

  assign w_out = {aquecedor, resfriador, irrigador,
                  lampada, dosador_base, dosador_acido};

  typedef struct {
    bit         rst;
    logic [3:0] s;
    logic [3:0] id;
    logic [5:0] exp;
    int         n;
  } vec_t;

  vec_t tab[$];

  int m_dir[4];
  int m_hold[4];
  int m_cnt;

  function automatic void add(bit r, int s, int i, logic [5:0] e, int n);
    vec_t v;
    v.rst = r; v.s = 4'(s); v.id = 4'(i); v.exp = e; v.n = n;
    tab.push_back(v);
  endfunction

  function automatic void addn(int k, logic [5:0] e, int n);
    for (int j = 0; j < k; j++) add(1'b0, 8, 8, e, n);
  endfunction

  function automatic int exp_ac(int n);
`ifdef CONTAGEM_ACIONAMENTOS_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  // per-channel direction: +1 raise actuator on, -1 lower on, 0 none
  function automatic void m_eval(int ch, int s, int id);
    int lo, hi, req, nd;
    lo  = (id - H < 0) ? 0 : id - H;
    hi  = (id + H > 15) ? 15 : id + H;
    req = (s < lo) ? 1 : ((s > hi) ? -1 : 0);
    if ((ch == 1 || ch == 2) && req < 0) req = 0;
    if (m_hold[ch] > 0) begin
      m_hold[ch]--;
      return;
    end
    nd = (req == 0 || m_dir[ch] == -req) ? 0 : req;
    if (nd != 0 && nd != m_dir[ch]) begin
      m_hold[ch] = MIN;
      m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    end
    m_dir[ch] = nd;
  endfunction

  function automatic logic [5:0] m_out();
    return {m_dir[0] == 1, m_dir[0] == -1, m_dir[1] == 1,
            m_dir[2] == 1, m_dir[3] == 1, m_dir[3] == -1};
  endfunction

  task automatic chk(input string nome, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nome, got, want);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_all(input logic [3:0] s[4], input logic [3:0] i[4]);
    temperatura = s[0]; umidade = s[1]; luminosidade = s[2]; pH = s[3];
    ideal_temperatura = i[0]; ideal_umidade = i[1];
    ideal_luminosidade = i[2]; ideal_pH = i[3];
  endtask

  task automatic rand_all();
    logic [3:0] s[4], i[4];
    for (int k = 0; k < 4; k++) begin
      s[k] = 4'($urandom_range(0, 15));
      i[k] = 4'($urandom_range(0, 15));
    end
    set_all(s, i);
  endtask

  task automatic drive_ch(input int ch, input logic [3:0] sv,
                          input logic [3:0] iv);
    logic [3:0] s[4], i[4];
    for (int k = 0; k < 4; k++) begin s[k] = 4'd8; i[k] = 4'd8; end
    s[ch] = sv;
    i[ch] = iv;
    set_all(s, i);
  endtask

  task automatic do_reset_start();
    enable = 1'b0;
    rand_all();
    reset = 1'b0;
    #3;
    chk("rst_out", 32'(w_out), 32'd0);
    chk("rst_canal", 32'(canal), 32'd0);
    chk("rst_ocup", 32'(ocupado), 32'd0);
    chk("rst_acion", 32'(acionamentos), 32'd0);
    step();
    reset = 1'b1;
    step();
    enable = 1'b1;
    step();
  endtask

  task automatic run_visit(input string tag, input logic [5:0] e_out,
                           input int e_canal, input int e_ac,
                           input bit scramble, input bit drop);
    step();
    if (scramble) rand_all();
    step();
    step();
    chk({tag, "_out"}, 32'(w_out), 32'(e_out));
    chk({tag, "_canal"}, 32'(canal), 32'(e_canal));
    chk({tag, "_acion"}, 32'(acionamentos), 32'(e_ac));
    chk({tag, "_ocup"}, 32'(ocupado), 32'd1);
    chk({tag, "_excl"},
        32'((aquecedor & resfriador) | (dosador_base & dosador_acido)),
        32'd0);
    if (drop) enable = 1'b0;
    repeat (PA) step();
  endtask

  initial begin
    int vi;
    int ch;
    logic [3:0] s[4], i[4];

    // raise then minimum on-time
    add(1'b1, 5, 10, 6'b100000, 1); addn(3, 6'b100000, 1);
    add(1'b0, 10, 10, 6'b100000, 1); addn(3, 6'b100000, 1);
    add(1'b0, 10, 10, 6'b100000, 1); addn(3, 6'b100000, 1);
    add(1'b0, 10, 10, 6'b000000, 1);
    // reversal
    add(1'b1, 5, 10, 6'b100000, 1); addn(3, 6'b100000, 1);
    add(1'b0, 15, 10, 6'b100000, 1); addn(3, 6'b100000, 1);
    add(1'b0, 15, 10, 6'b100000, 1); addn(3, 6'b100000, 1);
    add(1'b0, 15, 10, 6'b000000, 1); addn(3, 6'b000000, 1);
    add(1'b0, 15, 10, 6'b010000, 2);
    // band edges and saturation
    add(1'b1, 9, 10, 6'b000000, 0);
    add(1'b0, 15, 15, 6'b000000, 0);
    add(1'b0, 8, 10, 6'b000100, 1);
    add(1'b0, 0, 0, 6'b000100, 1);
    add(1'b0, 11, 10, 6'b000100, 1);
    add(1'b0, 0, 15, 6'b001100, 2);
    add(1'b0, 12, 10, 6'b001100, 2);
    add(1'b0, 8, 10, 6'b001110, 3);
    add(1'b0, 12, 10, 6'b011110, 4);

    vi = 0;
    for (int t = 0; t < tab.size(); t++) begin
      if (tab[t].rst) begin
        do_reset_start();
        vi = 0;
      end
      drive_ch(vi % 4, tab[t].s, tab[t].id);
      run_visit($sformatf("tab%0d", t), tab[t].exp, vi % 4,
                exp_ac(tab[t].n), 1'b0, 1'b0);
      vi++;
    end

    // reset asserted in the middle of ESPERA
    do_reset_start();
    drive_ch(0, 4'd5, 4'd10);
    step(); step(); step();
    chk("mid_on", 32'(aquecedor), 32'd1);
    step(); step();
    reset = 1'b0;
    #1;
    chk("mid_rst_out", 32'(w_out), 32'd0);
    chk("mid_rst_canal", 32'(canal), 32'd0);
    chk("mid_rst_ocup", 32'(ocupado), 32'd0);
    chk("mid_rst_acion", 32'(acionamentos), 32'd0);

    // enable dropped during canal 1, then resumed at canal 2
    do_reset_start();
    drive_ch(0, 4'd8, 4'd8);
    run_visit("par0", 6'b000000, 0, exp_ac(0), 1'b0, 1'b0);
    drive_ch(1, 4'd0, 4'd15);
    run_visit("par1", 6'b001000, 1, exp_ac(1), 1'b0, 1'b1);
    chk("park_ocup", 32'(ocupado), 32'd0);
    chk("park_canal", 32'(canal), 32'd2);
    chk("park_out", 32'(w_out), 32'b001000);
    drive_ch(2, 4'd15, 4'd0);
    repeat (5) step();
    chk("park2_ocup", 32'(ocupado), 32'd0);
    chk("park2_canal", 32'(canal), 32'd2);
    chk("park2_out", 32'(w_out), 32'b001000);
    drive_ch(2, 4'd8, 4'd10);
    enable = 1'b1;
    step();
    chk("resume_ocup", 32'(ocupado), 32'd1);
    chk("resume_canal", 32'(canal), 32'd2);
    run_visit("par2", 6'b001100, 2, exp_ac(2), 1'b0, 1'b0);

    // random visits against the direction model
    do_reset_start();
    for (int k = 0; k < 4; k++) begin m_dir[k] = 0; m_hold[k] = 0; end
    m_cnt = 0;
    ch = 0;
    for (int v = 0; v < 200; v++) begin
      for (int k = 0; k < 4; k++) begin
        s[k] = 4'($urandom_range(0, 15));
        i[k] = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) s[k] = 4'(i[k] + 4'($urandom_range(0, 3)) - 4'd2);
      end
      set_all(s, i);
      m_eval(ch, int'(s[ch]), int'(i[ch]));
      run_visit($sformatf("rnd%0d", v), m_out(), ch, exp_ac(m_cnt),
                1'b1, 1'b0);
      ch = (ch + 1) % 4;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acionador_estufa.md
Name: acionador_estufa

Overview:
- Actuation back-end of the greenhouse controller; drives outputs to the environment, where the scoring path only reads sensors.
- Visits the four sensor channels in round-robin and compares each 4-bit reading with its 4-bit ideal from the plant memory.
- Drives on/off actuators with a hysteresis band, a minimum on-time per channel and mutual exclusion of opposing actuators.
- Placed beside the scoring path; shares the sensor buses and the memory ideal_* outputs.

Parameters:
- HISTERESE, 1: half-width of the dead band, in sensor units (0..7).
- MIN_RONDAS, 2: minimum number of further channel evaluations an actuator stays on after turn-on (0..15).
- PAUSA, 4: ESPERA cycles per channel visit (1..255).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low.
- enable  in  1  run request.
- temperatura, umidade, luminosidade, pH  in  4 each  sensor readings.
- ideal_temperatura, ideal_umidade, ideal_luminosidade, ideal_pH  in  4 each  ideals from memory.
- aquecedor, resfriador  out  1 each  temperature channel (raise / lower).
- irrigador  out  1  humidity channel (raise only).
- lampada  out  1  luminosity channel (raise only).
- dosador_base, dosador_acido  out  1 each  pH channel (raise / lower).
- canal  out  2  channel being serviced: 0 temp, 1 umid, 2 lum, 3 pH.
- ocupado  out  1  high in every state except OCIOSO.
- acionamentos  out  8  see Optional Feature.

Behaviour:
- Reset (async, reset=0): all actuators 0, canal=0, ocupado=0, state OCIOSO, all per-channel hold counters 0, acionamentos=0.
- States:
  - OCIOSO: goes to AMOSTRA when enable=1.
  - AMOSTRA -> AVALIA: latches sensor and ideal of canal on this edge.
  - AVALIA -> ATUA: registers the decision.
  - ATUA -> ESPERA: actuator outputs update on this edge.
  - ESPERA: runs PAUSA cycles on a counter. At expiry, canal increments mod 4. Next state is AMOSTRA if enable=1, else OCIOSO.
- Timing: one visit = 3+PAUSA cycles; a round = 4 visits (28 cycles at defaults). The first actuator change is on the 4th edge after the first OCIOSO edge with enable=1.
- enable=0 mid-visit: the visit completes, then the block parks in OCIOSO. Outputs and canal hold; the next start resumes at the held canal.
- Band limits:
  - lo = ideal-HISTERESE, saturated at 0.
  - hi = ideal+HISTERESE, saturated at 15.
  - Compare in 5 bits, no wrap.
  - sensor<lo: request raise. sensor>hi: request lower. Otherwise: request none.
- Channels with one actuator (umid, lum): a lower request is treated as none.
- Hold counter per channel:
  - Loaded with MIN_RONDAS when any actuator of that channel turns on.
  - At each evaluation of that channel with counter>0: the actuators keep their current value and the counter decrements. No other change is allowed.
  - With counter=0, the requested actuator is set and the other cleared, with one exception below.
- Exception (reversal): if the opposing actuator is currently on, it turns off and the requested one stays off for this evaluation. The requested one may turn on at the next evaluation.
- Invariants: aquecedor&resfriador never 1; dosador_base&dosador_acido never 1.
- Inputs are sampled only in AMOSTRA; changes at any other time are ignored until the next visit of that channel.

Optional Feature:
- Macro: CONTAGEM_ACIONAMENTOS_EN.
- Defined: acionamentos counts actuator 0->1 transitions across all six outputs on ATUA edges. Simultaneous transitions on the same edge add their count. The counter saturates at 255; cleared only by reset.
- Undefined: acionamentos is constant 0 and no counter logic exists.

Test Plan:
1. Reset: pulse reset=0 with arbitrary inputs -> all actuators 0, canal=0, ocupado=0, acionamentos=0; asserting reset mid-ESPERA gives the same result immediately.
2. Raise:
   - Stimulus: temperatura=5, ideal_temperatura=10, defaults, enable=1.
   - Required: aquecedor=1 on the 4th edge and resfriador=0; with the macro on, acionamentos=1.
3. Minimum on-time: after test 2, set temperatura=10 -> aquecedor stays 1 at evaluations 2 and 3 of canal 0 and goes to 0 at evaluation 4 (round 4).
4. Reversal: after test 2, set temperatura=15 -> aquecedor 0 at evaluation 4; resfriador 1 at evaluation 5, never overlapping.
5. Band edges, ideal=10, H=1: sensor 9 or 11 -> no action. Sensor 12 -> lower; sensor 8 -> raise. ideal_pH=0 with pH=0 -> no dosing. ideal_umidade=15 with umidade=15 -> irrigador 0.
6. enable dropped during canal=1 ESPERA -> OCIOSO after PAUSA with canal=2 and outputs held; enable=1 resumes at canal 2.
